// File: rtl/ac_pkg.sv
// Shared types and smart-room default sizing for the air-conditioning regulator.
package ac_pkg;

    typedef enum logic [1:0] {
        AC_HOLD = 2'd0,
        AC_HEAT = 2'd1,
        AC_COOL = 2'd2
    } ac_mode_t;

    localparam int unsigned AC_WIDTH    = 6;
    localparam int unsigned AC_STEP     = 1;
    localparam int unsigned AC_DEADBAND = 0;

endpackage

// File: rtl/air_conditioning.sv
// One regulation step per clock: move the sensed temperature one STEP towards the
// setpoint without overshoot, and flag whether that step heated, cooled or held.
module air_conditioning
    import ac_pkg::*;
#(
    parameter int unsigned WIDTH    = AC_WIDTH,
    parameter int unsigned STEP     = AC_STEP,
    parameter int unsigned DEADBAND = AC_DEADBAND
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] temp,
    input  logic [WIDTH-1:0] ideal,
    output logic [WIDTH-1:0] out_temp,
    output logic             heat_on,
    output logic             cool_on,
    output logic             at_target
);

    localparam int unsigned EW = WIDTH + 1;

    logic [EW-1:0]    temp_x;
    logic [EW-1:0]    ideal_x;
    logic [EW-1:0]    step_x;
    logic [EW-1:0]    band_x;
    ac_mode_t         mode_c;
    logic [WIDTH-1:0] next_temp_c;

    assign temp_x  = {1'b0, temp};
    assign ideal_x = {1'b0, ideal};
    assign step_x  = EW'(STEP);
    assign band_x  = EW'(DEADBAND);

    // Decision and clamp; the extra bit keeps temp+STEP and ideal+STEP from wrapping.
    always_comb begin
        mode_c      = AC_HOLD;
        next_temp_c = temp;
        if (temp_x + band_x < ideal_x) begin
            mode_c = AC_HEAT;
            if (temp_x + step_x > ideal_x) begin
                next_temp_c = ideal;
            end else begin
                next_temp_c = WIDTH'(temp_x + step_x);
            end
        end else if (temp_x > ideal_x + band_x) begin
            mode_c = AC_COOL;
            if (temp_x < ideal_x + step_x) begin
                next_temp_c = ideal;
            end else begin
                next_temp_c = WIDTH'(temp_x - step_x);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_temp  <= '0;
            heat_on   <= 1'b0;
            cool_on   <= 1'b0;
            at_target <= 1'b0;
        end else begin
            out_temp  <= next_temp_c;
            heat_on   <= (mode_c == AC_HEAT);
            cool_on   <= (mode_c == AC_COOL);
            at_target <= (mode_c == AC_HOLD);
        end
    end

endmodule

// File: tb/tb_air_conditioning.sv
// Directed scoreboard bench: three regulator instances (default, STEP=4, DEADBAND=2)
// share the stimulus; expected values come from an integer reference model.
module tb_air_conditioning;

    typedef struct {
        logic [5:0] o;
        logic       h;
        logic       c;
        logic       a;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [5:0] temp;
    logic [5:0] ideal;

    logic [5:0] o0, o1, o2;
    logic       h0, h1, h2;
    logic       c0, c1, c2;
    logic       a0, a1, a2;

    int checks = 0;
    int errors = 0;

    exp_t  q0[$];
    exp_t  q1[$];
    exp_t  q2[$];
    string qtag[$];

    int last_out;

    air_conditioning #(.WIDTH(6), .STEP(1), .DEADBAND(0)) u_dut (
        .clk(clk), .rst(rst), .temp(temp), .ideal(ideal),
        .out_temp(o0), .heat_on(h0), .cool_on(c0), .at_target(a0)
    );

    air_conditioning #(.WIDTH(6), .STEP(4), .DEADBAND(0)) u_step4 (
        .clk(clk), .rst(rst), .temp(temp), .ideal(ideal),
        .out_temp(o1), .heat_on(h1), .cool_on(c1), .at_target(a1)
    );

    air_conditioning #(.WIDTH(6), .STEP(1), .DEADBAND(2)) u_db2 (
        .clk(clk), .rst(rst), .temp(temp), .ideal(ideal),
        .out_temp(o2), .heat_on(h2), .cool_on(c2), .at_target(a2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(int t, int i, int st, int db, bit r);
        exp_t m;
        int   o;
        m.o = '0; m.h = 1'b0; m.c = 1'b0; m.a = 1'b0;
        if (r) return m;
        if (t + db < i) begin
            o = t + st;
            if (o > i) o = i;
            m.h = 1'b1;
        end else if (t > i + db) begin
            o = t - st;
            if (o < i) o = i;
            m.c = 1'b1;
        end else begin
            o = t;
            m.a = 1'b1;
        end
        m.o = 6'(o);
        return m;
    endfunction

    task automatic check_field(string tag, int got, int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_inst(string tag, exp_t e, logic [5:0] o, logic h, logic c, logic a);
        check_field({tag, ".out_temp"},  int'(o), int'(e.o));
        check_field({tag, ".heat_on"},   int'(h), int'(e.h));
        check_field({tag, ".cool_on"},   int'(c), int'(e.c));
        check_field({tag, ".at_target"}, int'(a), int'(e.a));
    endtask

    // Drive one cycle of stimulus, record expectations, then compare after the edge.
    task automatic drive(string tag, int t, int i, bit r);
        exp_t e0, e1, e2;
        string tg;
        @(negedge clk);
        rst   = r;
        temp  = 6'(t);
        ideal = 6'(i);
        e0 = model(t, i, 1, 0, r);
        q0.push_back(e0);
        q1.push_back(model(t, i, 4, 0, r));
        q2.push_back(model(t, i, 1, 2, r));
        qtag.push_back(tag);
        last_out = int'(e0.o);
        @(posedge clk);
        #1;
        tg = qtag.pop_front();
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        e2 = q2.pop_front();
        check_inst({tg, "/base"},  e0, o0, h0, c0, a0);
        check_inst({tg, "/step4"}, e1, o1, h1, c1, a1);
        check_inst({tg, "/db2"},   e2, o2, h2, c2, a2);
    endtask

    initial begin
        rst   = 1'b1;
        temp  = '0;
        ideal = '0;
        last_out = 0;

        drive("reset", 17, 27, 1'b1);

        // Heating with out_temp fed back as the next sample.
        drive("heat1", 17, 27, 1'b0);
        drive("heat2", last_out, 27, 1'b0);
        drive("heat3", last_out, 27, 1'b0);

        drive("cool40", 40, 27, 1'b0);
        drive("hold27", 27, 27, 1'b0);

        drive("clamp25", 25, 27, 1'b0);
        drive("clamp30", 30, 27, 1'b0);

        drive("band25", 25, 27, 1'b0);
        drive("band24", 24, 27, 1'b0);
        drive("band29", 29, 27, 1'b0);
        drive("band30", 30, 27, 1'b0);

        drive("top62", 62, 63, 1'b0);
        drive("bot1", 1, 0, 1'b0);
        drive("max_cool", 63, 0, 1'b0);
        drive("max_heat", 0, 63, 1'b0);
        drive("hold63", 63, 63, 1'b0);
        drive("hold0", 0, 0, 1'b0);

        // Reset in the middle of a heating run, then resume.
        drive("mid1", 17, 27, 1'b0);
        drive("mid2", last_out, 27, 1'b0);
        drive("mid_rst", last_out, 27, 1'b1);
        drive("resume", 19, 27, 1'b0);
        drive("resume2", last_out, 27, 1'b0);

        // Setpoint change takes effect on the very next edge.
        drive("ideal_dn", 30, 10, 1'b0);
        drive("ideal_up", 30, 50, 1'b0);

        for (int k = 0; k < 20; k++) begin
            drive("rand", int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
